// File: rtl/frotaegis_pkg.sv
// Shared definitions for the histogram collector: state encoding,
// default parameter values and the count-width helper.
package frotaegis_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } hist_state_t;

  localparam int DEF_DATA_SIZE   = 4;
  localparam int DEF_DATA_NUM    = 16;
  localparam int DEF_LENGTH      = 64;
  localparam int DEF_LENGTH_SIZE = 6;

  // One extra bit so a single bin can hold the full LENGTH without wrapping.
  function automatic int count_w(input int length_size);
    return length_size + 1;
  endfunction

endpackage

// File: rtl/bin_counter.sv
// One histogram bin: a saturation-free occurrence counter with
// synchronous clear and increment enable.
module bin_counter #(
  parameter int COUNT_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               inc,
  output logic [COUNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/hist_collector.sv
// Captures a window of LENGTH samples into DATA_NUM bins, then streams
// the bin counts out one beat per handshake.
module hist_collector
  import frotaegis_pkg::*;
#(
  parameter int  DATA_SIZE   = DEF_DATA_SIZE,
  parameter int  DATA_NUM    = DEF_DATA_NUM,
  parameter int  LENGTH      = DEF_LENGTH,
  parameter int  LENGTH_SIZE = DEF_LENGTH_SIZE,
  localparam int COUNT_W     = count_w(LENGTH_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Collect,
  input  logic                 Valid,
  input  logic [DATA_SIZE-1:0] Data,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [DATA_SIZE-1:0] Out_Bin,
  output logic [COUNT_W-1:0]   Out_Count,
  output logic                 Out_Last
);

  localparam logic [DATA_SIZE-1:0] LAST_BIN   = DATA_SIZE'(DATA_NUM - 1);
  localparam logic [COUNT_W-1:0]   LAST_COUNT = COUNT_W'(LENGTH - 1);

  hist_state_t            state;
  hist_state_t            state_nxt;
  logic                   clear_all;
  logic                   accept;
  logic                   last_sample;
  logic [COUNT_W-1:0]     sample_cnt;
  logic [DATA_SIZE-1:0]   idx;
  logic [DATA_SIZE-1:0]   idx_nxt;
  logic [DATA_NUM-1:0]    bin_hit;
  logic [COUNT_W-1:0]     bin_count [DATA_NUM];

  assign last_sample = (sample_cnt == LAST_COUNT);
  assign idx_nxt     = idx + DATA_SIZE'(1);
  assign Out_Bin     = idx;
  assign Busy        = (state == CAPTURE) || (state == DRAIN);
  assign Done        = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clear_all = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (Collect) begin
          clear_all = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        accept = Valid;
        if (Valid && last_sample) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (Out_Valid && Out_Ready && Out_Last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A sample that matches no bin is out of range: counted, not binned.
  for (genvar i = 0; i < DATA_NUM; i++) begin : g_bin
    assign bin_hit[i] = (Data == DATA_SIZE'(i));

    bin_counter #(
      .COUNT_W (COUNT_W)
    ) u_bin (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_all),
      .inc   (accept & bin_hit[i]),
      .count (bin_count[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      Err        <= 1'b0;
    end else if (clear_all) begin
      sample_cnt <= '0;
      Err        <= 1'b0;
    end else if (accept) begin
      sample_cnt <= sample_cnt + COUNT_W'(1);
      if (!(|bin_hit)) begin
        Err <= 1'b1;
      end
    end
  end

  // First beat loads on the cycle after entering DRAIN; later beats
  // reload straight from the next bin so a held-high Ready streams.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      Out_Valid <= 1'b0;
      Out_Count <= '0;
      Out_Last  <= 1'b0;
    end else if (clear_all) begin
      idx       <= '0;
      Out_Valid <= 1'b0;
      Out_Count <= '0;
      Out_Last  <= 1'b0;
    end else if (state == DRAIN) begin
      if (!Out_Valid) begin
        Out_Valid <= 1'b1;
        Out_Count <= bin_count[idx];
        Out_Last  <= (idx == LAST_BIN);
      end else if (Out_Ready) begin
        if (Out_Last) begin
          idx       <= '0;
          Out_Valid <= 1'b0;
          Out_Count <= '0;
          Out_Last  <= 1'b0;
        end else begin
          idx       <= idx_nxt;
          Out_Count <= bin_count[idx_nxt];
          Out_Last  <= (idx_nxt == LAST_BIN);
        end
      end
    end
  end

endmodule
